// File: rtl/rain_display_sequencer.sv
// Time-shares one digit-display driver between three 5-digit BCD pages, rotating pages on a
// dwell timer or the Mode button and streaming each frame one digit per valid/ready handshake.
module rain_display_sequencer #(
    parameter int unsigned DWELL_TICKS   = 5,
    parameter int unsigned REFRESH_TICKS = 1,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_1hz_i,
    input  logic        n_mode_i,
    input  logic [2:0]  page_enable_i,
    input  logic [19:0] page0_digits_i,
    input  logic [19:0] page1_digits_i,
    input  logic [19:0] page2_digits_i,
    input  logic        digit_ready_i,
    output logic        digit_valid_o,
    output logic [2:0]  digit_index_o,
    output logic [3:0]  digit_value_o,
    output logic        digit_dp_o,
    output logic [1:0]  page_sel_o,
    output logic        frame_done_o
);

    localparam int unsigned DwellW   = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int unsigned RefreshW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [DwellW-1:0]   DwellLast   = DwellW'(DWELL_TICKS - 1);
    localparam logic [RefreshW-1:0] RefreshLast = RefreshW'(REFRESH_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          page_sel_q, page_sel_d;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [RefreshW-1:0] refresh_q, refresh_d;
    logic                pending_q, pending_d;
    logic                mode_prev_q;
    logic [2:0]          idx_q, idx_d;
    logic [19:0]         snap_q, snap_d;

    logic [1:0]  cand1, cand2, next_page;
    logic        cur_enabled, mode_fall, dwell_expire, refresh_hit;
    logic        idle_req, force_adv, advance, start_frame;
    logic [19:0] raw_digits, load_digits;

    function automatic logic [1:0] inc_page(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Next enabled page in rotation order; holds when no other page is enabled.
    always_comb begin
        cand1 = inc_page(page_sel_q);
        cand2 = inc_page(cand1);
        if (page_enable_i[cand1]) begin
            next_page = cand1;
        end else if (page_enable_i[cand2]) begin
            next_page = cand2;
        end else begin
            next_page = page_sel_q;
        end
    end

    assign cur_enabled  = page_enable_i[page_sel_q];
    assign mode_fall    = mode_prev_q & ~n_mode_i;
    assign dwell_expire = tick_1hz_i & (dwell_q == DwellLast);
    assign refresh_hit  = refresh_q == RefreshLast;
    assign idle_req     = (state_q == StIdle) & pending_q;
    assign force_adv    = idle_req & ~cur_enabled & (|page_enable_i);
    assign advance      = mode_fall | dwell_expire | force_adv;
    assign start_frame  = idle_req & cur_enabled;

    // A new request in the same cycle a frame starts wins over the clear.
    always_comb begin
        page_sel_d = page_sel_q;
        dwell_d    = dwell_q;
        refresh_d  = refresh_q;
        pending_d  = pending_q;
        if (start_frame) begin
            pending_d = 1'b0;
        end
        if (advance) begin
            page_sel_d = next_page;
            dwell_d    = '0;
            refresh_d  = '0;
            pending_d  = 1'b1;
        end else if (tick_1hz_i) begin
            dwell_d = dwell_q + 1'b1;
            if (refresh_hit) begin
                refresh_d = '0;
                pending_d = 1'b1;
            end else begin
                refresh_d = refresh_q + 1'b1;
            end
        end
    end

    always_comb begin
        unique case (page_sel_q)
            2'd1:    raw_digits = page1_digits_i;
            2'd2:    raw_digits = page2_digits_i;
            default: raw_digits = page0_digits_i;
        endcase
        load_digits = raw_digits;
        if (BLANK_LEADING && raw_digits[19:16] == 4'd0) begin
            load_digits[19:16] = BLANK_CODE;
            if (raw_digits[15:12] == 4'd0) begin
                load_digits[15:12] = BLANK_CODE;
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        snap_d = snap_q;
        if (state_q == StLoad) begin
            idx_d  = 3'd4;
            snap_d = load_digits;
        end else if (state_q == StSend && digit_ready_i && idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            page_sel_q  <= 2'd0;
            dwell_q     <= '0;
            refresh_q   <= '0;
            pending_q   <= 1'b1;
            mode_prev_q <= 1'b1;
            idx_q       <= 3'd0;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            page_sel_q  <= page_sel_d;
            dwell_q     <= dwell_d;
            refresh_q   <= refresh_d;
            pending_q   <= pending_d;
            mode_prev_q <= n_mode_i;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_frame) state_d = StLoad;
            StLoad: state_d = StSend;
            StSend: if (digit_ready_i && idx_q == 3'd0) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        digit_valid_o = 1'b0;
        digit_index_o = 3'd0;
        digit_value_o = 4'd0;
        digit_dp_o    = 1'b0;
        frame_done_o  = 1'b0;
        unique case (state_q)
            StSend: begin
                digit_valid_o = 1'b1;
                digit_index_o = idx_q;
                digit_value_o = snap_q[{idx_q, 2'b00} +: 4];
                digit_dp_o    = (idx_q == 3'd2);
            end
            StDone: frame_done_o = 1'b1;
            default: ;
        endcase
    end

    assign page_sel_o = page_sel_q;

endmodule

// File: tb/tb_rain_display_sequencer.sv
// Self-checking bench: directed sequences, a digit table, and randomized runs checked against a
// page-rotation/frame reference model.
module tb_rain_display_sequencer;

    localparam int DWELL = 5;

    logic        clk = 1'b0;
    logic        rst, tick, n_mode, ready;
    logic [2:0]  en;
    logic [19:0] pd0, pd1, pd2;
    logic        valid, dp, fdone;
    logic [2:0]  idx;
    logic [3:0]  val;
    logic [1:0]  psel;

    rain_display_sequencer #(
        .DWELL_TICKS  (DWELL),
        .REFRESH_TICKS(1),
        .BLANK_LEADING(1'b1),
        .BLANK_CODE   (4'hF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_1hz_i    (tick),
        .n_mode_i      (n_mode),
        .page_enable_i (en),
        .page0_digits_i(pd0),
        .page1_digits_i(pd1),
        .page2_digits_i(pd2),
        .digit_ready_i (ready),
        .digit_valid_o (valid),
        .digit_index_o (idx),
        .digit_value_o (val),
        .digit_dp_o    (dp),
        .page_sel_o    (psel),
        .frame_done_o  (fdone)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int m_page = 0, m_dwell = 0, f_next = -1, frames = 0, n_hs = 0;
    bit m_prev = 1'b1;
    logic [3:0] f_exp [5];
    logic [3:0] cap [5];

    typedef struct {
        logic [19:0] digits;
        logic [19:0] exp_digits;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    function automatic logic [19:0] get_pd(input int p);
        case (p)
            1:       return pd1;
            2:       return pd2;
            default: return pd0;
        endcase
    endfunction

    function automatic int next_en(input int p);
        for (int k = 1; k <= 2; k++) if (en[(p + k) % 3]) return (p + k) % 3;
        return p;
    endfunction

    // One clock: model update from the inputs held across the edge, then output checks.
    task automatic step();
        logic pv, pr, pdp, prst, fall, expire;
        logic [2:0] pidx;
        logic [3:0] pval;
        logic [19:0] d;
        int ppage;
        bit hs;
        pv = valid; pr = ready; pdp = dp; pidx = idx; pval = val; prst = rst; ppage = m_page;
        @(posedge clk);
        if (prst) begin
            m_page = 0; m_dwell = 0; m_prev = 1'b1; f_next = -1;
        end else begin
            fall   = m_prev && !n_mode;
            expire = tick && (m_dwell + 1 == DWELL);
            if (fall || expire) begin
                m_page  = next_en(m_page);
                m_dwell = 0;
            end else if (tick) begin
                m_dwell++;
            end
            m_prev = n_mode;
        end
        #1;
        chk("page_sel", psel, m_page);
        if (prst) begin
            chk("rst_valid", valid, 0);
            chk("rst_index", idx, 0);
            chk("rst_value", val, 0);
            chk("rst_dp", dp, 0);
            chk("rst_frame_done", fdone, 0);
            return;
        end
        hs = pv && pr;
        chk("frame_done", fdone, int'(hs && pidx == 3'd0));
        if (hs) begin
            n_hs++;
            chk("digit_index", pidx, f_next);
            chk("digit_value", pval, f_exp[pidx]);
            chk("digit_dp", pdp, int'(pidx == 3'd2));
            cap[pidx] = pval;
            f_next--;
            if (pidx == 3'd0) begin
                frames++;
                f_next = -1;
            end
        end else if (pv) begin
            chk("hold_valid", valid, 1);
            chk("hold_index", idx, pidx);
            chk("hold_value", val, pval);
            chk("hold_dp", dp, pdp);
        end
        if (valid && !pv) begin
            chk("frame_start_index", idx, 4);
            d = get_pd(ppage);
            for (int i = 0; i < 5; i++) f_exp[i] = d[4*i +: 4];
            if (d[19:16] == 4'd0) begin
                f_exp[4] = 4'hF;
                if (d[15:12] == 4'd0) f_exp[3] = 4'hF;
            end
            f_next = 4;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_frame(input string nm);
        int start, n;
        start = frames;
        n = 0;
        while (frames == start && n < 100) begin
            step();
            n++;
        end
        chk(nm, frames - start, 1);
    endtask

    task automatic do_reset(input logic [2:0] e);
        rst = 1'b1; en = e; tick = 1'b0; n_mode = 1'b1; ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press();
        n_mode = 1'b0;
        step();
        n_mode = 1'b1;
        repeat (10) step();
    endtask

    task automatic random_segment(input logic [2:0] e, input int cycles);
        int f0;
        pd0 = 20'($urandom); pd1 = 20'($urandom); pd2 = 20'($urandom);
        if ($urandom_range(0, 1) == 1) pd0[19:12] = 8'h00;
        if ($urandom_range(0, 1) == 1) pd1[19:16] = 4'h0;
        do_reset(e);
        f0 = frames;
        for (int c = 0; c < cycles; c++) begin
            tick = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) n_mode = ~n_mode;
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rand_frames_seen", int'(frames > f0), 1);
    endtask

    initial begin
        int n, hs0, nval;
        logic [19:0] t1exp, ev;

        vecs[0] = '{20'h00728, 20'hFF728};
        vecs[1] = '{20'h12345, 20'h12345};
        vecs[2] = '{20'h00000, 20'hFF000};
        vecs[3] = '{20'h01000, 20'hF1000};
        vecs[4] = '{20'h10000, 20'h10000};
        vecs[5] = '{20'hABCDE, 20'hABCDE};
        vecs[6] = '{20'h0C9A0, 20'hFC9A0};

        pd0 = 20'h00728; pd1 = 20'h12345; pd2 = 20'h09A0B;

        // Frame right after reset, blanked leading zeros.
        do_reset(3'b111);
        wait_valid(n);
        chk("t1_latency", n, 2);
        wait_frame("t1_frame");
        t1exp = 20'hFF728;
        for (int i = 0; i < 5; i++) chk("t1_digit", cap[i], t1exp[4*i +: 4]);

        // Stall at index 3 for three cycles.
        repeat (3) step();
        hs0 = n_hs;
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_valid(n);
        chk("t2_refresh_latency", n, 2);
        n = 0;
        while (!(valid && idx == 3'd3) && n < 20) begin
            step();
            n++;
        end
        ready = 1'b0;
        repeat (3) step();
        ready = 1'b1;
        wait_frame("t2_frame");
        chk("t2_handshakes", n_hs - hs0, 5);

        // Dwell expiry on the fifth tick.
        do_reset(3'b111);
        wait_frame("t3_first_frame");
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (k == 4) chk("t3_page_after4", psel, 0);
            repeat (12) step();
        end
        chk("t3_page_after5", psel, 1);
        chk("t3_page1_d4", cap[4], 1);
        chk("t3_page1_d0", cap[0], 5);

        // Button edge coinciding with the expiry tick.
        for (int k = 1; k <= 4; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (12) step();
        end
        tick = 1'b1; n_mode = 1'b0;
        step();
        tick = 1'b0;
        step();
        chk("t4_single_advance", psel, 2);
        n_mode = 1'b1;
        repeat (12) step();

        // Skipping a disabled page, then nothing enabled.
        do_reset(3'b101);
        chk("t5_seq0", psel, 0);
        wait_frame("t5_frame");
        press();
        chk("t5_seq1", psel, 2);
        press();
        chk("t5_seq2", psel, 0);
        do_reset(3'b000);
        nval = 0;
        for (int c = 0; c < 40; c++) begin
            tick   = (c % 5 == 0);
            n_mode = (c != 17);
            step();
            if (valid) nval++;
        end
        tick = 1'b0; n_mode = 1'b1;
        chk("t5_no_valid", nval, 0);
        chk("t5_page_hold", psel, 0);
        en = 3'b111;
        wait_valid(n);
        chk("t5_pending_kept", n, 2);

        // Reset in the middle of a frame.
        n = 0;
        while (!(valid && idx == 3'd2) && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        chk("t6_valid_cleared", valid, 0);
        chk("t6_done_cleared", fdone, 0);
        rst = 1'b0;
        wait_valid(n);
        chk("t6_restart_index", idx, 4);
        wait_frame("t6_frame");

        // Digit table on a single-page rotation.
        do_reset(3'b001);
        wait_frame("tbl_first_frame");
        for (int v = 0; v < 7; v++) begin
            repeat (3) step();
            pd0 = vecs[v].digits;
            n_mode = 1'b0;
            step();
            n_mode = 1'b1;
            wait_frame("tbl_frame");
            ev = vecs[v].exp_digits;
            for (int i = 0; i < 5; i++) chk("tbl_digit", cap[i], ev[4*i +: 4]);
            chk("tbl_page", psel, 0);
        end

        random_segment(3'b111, 2500);
        random_segment(3'b101, 2000);
        random_segment(3'b011, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
